evt_or_source_decoder: RTL and testbench

- Receive-side counterpart to the 4-input OR request combiner.
- Captures four independent event lines into sticky pending bits and drives a summary interrupt, which is the OR of the pending bits.
- Reports the source index of each pending event, one at a time, over a valid/ready handshake; arbitration is round-robin.
- Sits between raw event producers and the interrupt-servicing logic, which needs to know which source fired, not just that one did.

---
 rtl/evt_or_source_decoder.sv | 82 ++++++++
 tb/tb_evt_or_source_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/evt_or_source_decoder.sv
// evt_or_source_decoder: sticky event capture with round-robin source-id reporting; EVT_OVF_CNT_EN adds a dropped-event counter
module evt_or_source_decoder #(
    parameter int EDGE_MODE = 1
`ifdef EVT_OVF_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] evt_i,
    output logic       irq_o,
    output logic [3:0] pending_o,
    output logic       id_valid_o,
    input  logic       id_ready_i,
    output logic [1:0] id_o
`ifdef EVT_OVF_CNT_EN
    , output logic [CNT_W-1:0] ovf_cnt_o
`endif
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, state_nx;
    logic [3:0] evt_q, set, clr, pend_nx;
    logic [1:0] ptr, ptr_nx, id_nx;
    logic hs;
    // first requester at or after p, wrapping mod 4
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
        logic [1:0] w, c;
        w = p;
        for (int k = 3; k >= 0; k--) begin
            c = p + 2'(k);
            if (req[c]) w = c;
        end
        return w;
    endfunction
    assign set        = EDGE_MODE != 0 ? evt_i & ~evt_q : evt_i;
    assign hs         = id_valid_o & id_ready_i;
    assign clr        = hs ? 4'b0001 << id_o : 4'b0000;
    assign pend_nx    = set | (pending_o & ~clr);
    assign irq_o      = |pending_o;
    assign id_valid_o = state == PRESENT;
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        id_nx    = id_o;
        if (state == IDLE) begin
            state_nx = |pending_o ? PRESENT : IDLE;
            id_nx    = |pending_o ? rr_pick(pending_o, ptr) : id_o;
        end else if (hs) begin
            ptr_nx   = id_o + 2'd1;
            state_nx = |pend_nx ? PRESENT : IDLE;
            id_nx    = |pend_nx ? rr_pick(pend_nx, id_o + 2'd1) : id_o;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            id_o      <= 2'd0;
            evt_q     <= 4'd0;
            pending_o <= 4'd0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            id_o      <= id_nx;
            evt_q     <= evt_i;
            pending_o <= pend_nx;
        end
    end
`ifdef EVT_OVF_CNT_EN
    localparam int SW = CNT_W + 3;
    logic [3:0] lost;
    logic [2:0] lost_n;
    logic [SW-1:0] sum;
    assign lost   = set & pending_o & ~clr;
    assign lost_n = 3'(lost[0]) + 3'(lost[1]) + 3'(lost[2]) + 3'(lost[3]);
    assign sum    = SW'(ovf_cnt_o) + SW'(lost_n);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_cnt_o <= '0;
        else     ovf_cnt_o <= sum > SW'({CNT_W{1'b1}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
`endif
endmodule

// File: tb/tb_evt_or_source_decoder.sv
// tb_evt_or_source_decoder: scoreboard bench with a behavioural reference model of the event decoder
module tb_evt_or_source_decoder;
    logic       clk = 0, rst, irq_o, id_valid_o, id_ready_i;
    logic [3:0] evt_i, pending_o;
    logic [1:0] id_o;
    int errors = 0, checks = 0;
`ifdef EVT_OVF_CNT_EN
    logic [1:0] ovf_cnt_o;
    int m_ovf;
    evt_or_source_decoder #(.EDGE_MODE(1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .evt_i(evt_i), .irq_o(irq_o), .pending_o(pending_o),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_o(id_o), .ovf_cnt_o(ovf_cnt_o));
`else
    evt_or_source_decoder #(.EDGE_MODE(1)) dut (
        .clk(clk), .rst(rst), .evt_i(evt_i), .irq_o(irq_o), .pending_o(pending_o),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_o(id_o));
`endif
    always #5 clk = ~clk;

    bit [3:0] m_pend, m_evq;
    int m_ptr, m_id, m_valid;
    int exp_q[$];
    int hs_log[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input bit [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    // reference model: sources set on rising edges, ids granted round-robin from the pointer
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_evq = 0; m_ptr = 0; m_id = 0; m_valid = 0;
            exp_q.delete();
`ifdef EVT_OVF_CNT_EN
            m_ovf = 0;
`endif
        end else begin
            bit [3:0] setv, nxt;
            int hs, cid;
            hs = m_valid && id_ready_i;
            cid = hs ? m_id : -1;
            nxt = m_pend;
            for (int i = 0; i < 4; i++) begin
                setv[i] = evt_i[i] && !m_evq[i];
`ifdef EVT_OVF_CNT_EN
                if (setv[i] && m_pend[i] && i != cid) m_ovf = (m_ovf < 3) ? m_ovf + 1 : 3;
`endif
                if (i == cid) nxt[i] = 0;
                if (setv[i]) nxt[i] = 1;
            end
            if (!m_valid) begin
                if (m_pend != 0) begin
                    m_id = pick(m_pend, m_ptr); m_valid = 1; exp_q.push_back(m_id);
                end
            end else if (hs) begin
                m_ptr = (m_id + 1) % 4;
                if (nxt != 0) begin
                    m_id = pick(nxt, m_ptr); exp_q.push_back(m_id);
                end else m_valid = 0;
            end
            m_pend = nxt;
            m_evq = evt_i;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("pending", int'(pending_o), int'(m_pend));
            chk("irq", int'(irq_o), int'(m_pend != 0));
            chk("id_valid", int'(id_valid_o), m_valid);
`ifdef EVT_OVF_CNT_EN
            chk("ovf_cnt", int'(ovf_cnt_o), m_ovf);
`endif
            if (id_valid_o && id_ready_i) begin
                hs_log.push_back(int'(id_o));
                if (exp_q.size() == 0) chk("hs_unexpected", int'(id_o), -1);
                else chk("hs_id", int'(id_o), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        hs_log.delete();
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, hs_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < hs_log.size(); i++) chk(name, hs_log[i], exp[i]);
    endtask

    initial begin
        rst = 1; evt_i = 0; id_ready_i = 0;
        tick(); tick();
        chk("rst_pending", int'(pending_o), 0);
        chk("rst_irq", int'(irq_o), 0);
        chk("rst_valid", int'(id_valid_o), 0);
        chk("rst_id", int'(id_o), 0);
        rst = 0;
        // single event held until acknowledged
        evt_i = 4'b0100; tick(); evt_i = 0;
        chk("t1_pending", int'(pending_o), 4);
        chk("t1_irq", int'(irq_o), 1);
        chk("t1_valid0", int'(id_valid_o), 0);
        tick();
        chk("t1_valid", int'(id_valid_o), 1);
        chk("t1_id", int'(id_o), 2);
        tick(); tick();
        chk("t1_hold_valid", int'(id_valid_o), 1);
        chk("t1_hold_id", int'(id_o), 2);
        id_ready_i = 1; tick(); id_ready_i = 0;
        chk("t1_done_pending", int'(pending_o), 0);
        chk("t1_done_irq", int'(irq_o), 0);
        chk("t1_done_valid", int'(id_valid_o), 0);
        // round robin over all sources, twice
        do_reset();
        id_ready_i = 1;
        evt_i = 4'b1111; tick(); evt_i = 0;
        repeat (6) tick();
        evt_i = 4'b1111; tick(); evt_i = 0;
        repeat (6) tick();
        id_ready_i = 0;
        chk_log("rr", '{0, 1, 2, 3, 0, 1, 2, 3});
        // fairness: source 0 re-fires while being acked, 3 goes first
        do_reset();
        evt_i = 4'b1001; tick(); evt_i = 0;
        tick();
        id_ready_i = 1; evt_i = 4'b0001; tick(); evt_i = 0;
        chk("fair_id", int'(id_o), 3);
        repeat (3) tick();
        id_ready_i = 0;
        chk_log("fair", '{0, 3, 0});
        // set/clear collision on source 1
        do_reset();
        evt_i = 4'b0010; tick(); evt_i = 0;
        tick();
        id_ready_i = 1; evt_i = 4'b0010; tick(); evt_i = 0; id_ready_i = 0;
        chk("coll_pending", int'(pending_o), 2);
        chk("coll_valid", int'(id_valid_o), 1);
        chk("coll_id", int'(id_o), 1);
        id_ready_i = 1; tick(); tick(); id_ready_i = 0;
        chk_log("coll", '{1, 1});
`ifdef EVT_OVF_CNT_EN
        do_reset();
        repeat (5) begin
            evt_i = 4'b0001; tick(); evt_i = 0; tick();
        end
        chk("ovf_sat", int'(ovf_cnt_o), 3);
        id_ready_i = 1; repeat (4) tick(); id_ready_i = 0;
        chk_log("ovf", '{0});
`endif
        // randomized traffic against the model
        do_reset();
        repeat (400) begin
            evt_i = 4'($urandom_range(0, 15));
            id_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        evt_i = 0; id_ready_i = 1;
        begin
            int n = 0;
            while ((exp_q.size() != 0 || m_valid != 0) && n < 50) begin tick(); n++; end
            chk("drain_timeout", n < 50 ? 1 : 0, 1);
        end
        id_ready_i = 0;
        // asynchronous reset while presenting
        do_reset();
        evt_i = 4'b0001; tick(); evt_i = 0;
        tick();
        chk("ar_valid_pre", int'(id_valid_o), 1);
        #1 rst = 1;
        #1;
        chk("ar_valid", int'(id_valid_o), 0);
        chk("ar_irq", int'(irq_o), 0);
        chk("ar_pending", int'(pending_o), 0);
        chk("ar_id", int'(id_o), 0);
        tick(); rst = 0;
        tick(); tick();
        chk("ar_no_repeat", int'(id_valid_o), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
